// File: rtl/median_scan_ctrl_pkg.sv
// Shared definitions for the median-filter raster-scan controller: FSM state
// encodings and default frame geometry.
package median_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;
  localparam int DEF_CNT_W  = 10;
  localparam int DEF_ADDR_W = 19;

endpackage

// File: rtl/median_scan_ctrl_scan_pos_counter.sv
// Wrap counter for one scan coordinate: counts 0..MAX_VAL on inc_i, returns to
// 0 after MAX_VAL and raises wrap_o combinationally in that cycle as a carry.
module scan_pos_counter
  import median_scan_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_VAL = DEF_IMG_W - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = inc_i && (cnt_q == MAX_CNT);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/median_scan_ctrl.sv
// Raster-scan controller ahead of the 3x3 median window datapath.
// Optional MEDIAN_BORDER_REPLICATE_EN: emit border centres too, with a FLUSH state.
module median_scan_ctrl
  import median_scan_ctrl_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  output logic [CNT_W-1:0]  col_o,
  output logic [CNT_W-1:0]  row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              pix_acc_o,
  output logic              win_valid_o,
  output logic [CNT_W-1:0]  center_col_o,
  output logic [CNT_W-1:0]  center_row_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q;
  logic              ready_q, busy_q, done_q, acc_q, win_q;
  logic [CNT_W-1:0]  col_q, row_q, ccol_q, crow_q;
  logic [ADDR_W-1:0] addr_q, addr_cnt_q, addr_cnt_d;

  logic [CNT_W-1:0]  col_cnt, row_cnt;
  logic              col_wrap, row_wrap;
  logic              accept, frame_clr, last_pix;
  logic              win_fire;
  logic [CNT_W-1:0]  win_col, win_row;

  // abort_i outranks a pending pixel so an aborted frame never strobes again
  assign accept    = ready_q && pix_valid_i && !abort_i;
  assign frame_clr = (state_q == ST_IDLE) && start_i && !abort_i;
  assign last_pix  = row_wrap;

  scan_pos_counter #(.CNT_W(CNT_W), .MAX_VAL(IMG_W - 1)) u_col (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (frame_clr),
    .inc_i (accept),
    .cnt_o (col_cnt),
    .wrap_o(col_wrap)
  );

  scan_pos_counter #(.CNT_W(CNT_W), .MAX_VAL(IMG_H - 1)) u_row (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (frame_clr),
    .inc_i (col_wrap),
    .cnt_o (row_cnt),
    .wrap_o(row_wrap)
  );

  always_comb begin
    addr_cnt_d = addr_cnt_q;
    if (frame_clr) begin
      addr_cnt_d = '0;
    end else if (accept) begin
      addr_cnt_d = addr_cnt_q + ADDR_W'(1);
    end
  end

`ifdef MEDIAN_BORDER_REPLICATE_EN
  // Centres trail the input by one row plus one pixel, so every centre's
  // lower-right neighbour exists (or is a clamped border) when it is emitted.
  localparam logic [ADDR_W-1:0] WIN_LAG = ADDR_W'(IMG_W + 1);
  logic cen_wrap, flush_last;

  assign win_fire = (accept && (addr_cnt_q >= WIN_LAG)) ||
                    ((state_q == ST_FLUSH) && !abort_i);

  scan_pos_counter #(.CNT_W(CNT_W), .MAX_VAL(IMG_W - 1)) u_ccol (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (frame_clr),
    .inc_i (win_fire),
    .cnt_o (win_col),
    .wrap_o(cen_wrap)
  );

  scan_pos_counter #(.CNT_W(CNT_W), .MAX_VAL(IMG_H - 1)) u_crow (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (frame_clr),
    .inc_i (cen_wrap),
    .cnt_o (win_row),
    .wrap_o(flush_last)
  );
`else
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  assign win_fire = accept && (row_cnt >= CNT_TWO) && (col_cnt >= CNT_TWO);
  assign win_col  = col_cnt - CNT_ONE;
  assign win_row  = row_cnt - CNT_ONE;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= 1'b0;
      win_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      ccol_q     <= '0;
      crow_q     <= '0;
      addr_cnt_q <= '0;
    end else begin
      acc_q      <= accept;
      win_q      <= win_fire;
      addr_cnt_q <= addr_cnt_d;
      // done_o is registered out of DONE, so an abort during DONE still cancels it
      done_q     <= (state_q == ST_DONE) && !abort_i;
      if (accept) begin
        col_q  <= col_cnt;
        row_q  <= row_cnt;
        addr_q <= addr_cnt_q;
      end
      if (win_fire) begin
        ccol_q <= win_col;
        crow_q <= win_row;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_clr) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (last_pix) begin
`ifdef MEDIAN_BORDER_REPLICATE_EN
            state_q <= ST_FLUSH;
`else
            state_q <= ST_DONE;
`endif
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
`ifdef MEDIAN_BORDER_REPLICATE_EN
        ST_FLUSH: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (flush_last) begin
            state_q <= ST_DONE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always @(posedge CLK) begin
    if (!RST && acc_q) begin
      assert (int'(addr_q) == int'(row_q) * IMG_W + int'(col_q));
    end
  end

  assign pix_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pix_acc_o    = acc_q;
  assign win_valid_o  = win_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign addr_o       = addr_q;
  assign center_col_o = ccol_q;
  assign center_row_o = crow_q;

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Self-checking bench for median_scan_ctrl: a 4x3 instance and a 5x4 instance
// share the stimulus; sel picks which one is being observed.
`timescale 1ns/1ps
module tb_median_scan_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start_i = 1'b0, abort_i = 1'b0, pix_valid_i = 1'b0;
  always #5 CLK = ~CLK;

  logic a_ready, a_acc, a_win, a_busy, a_done;
  logic [9:0] a_col, a_row, a_ccol, a_crow;
  logic [18:0] a_addr;
  logic b_ready, b_acc, b_win, b_busy, b_done;
  logic [9:0] b_col, b_row, b_ccol, b_crow;
  logic [18:0] b_addr;

  median_scan_ctrl #(.IMG_W(4), .IMG_H(3), .CNT_W(10), .ADDR_W(19)) dut_a (
    .CLK(CLK), .RST(RST), .start_i(start_i), .abort_i(abort_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(a_ready), .col_o(a_col), .row_o(a_row),
    .addr_o(a_addr), .pix_acc_o(a_acc), .win_valid_o(a_win), .center_col_o(a_ccol),
    .center_row_o(a_crow), .busy_o(a_busy), .done_o(a_done)
  );

  median_scan_ctrl #(.IMG_W(5), .IMG_H(4), .CNT_W(10), .ADDR_W(19)) dut_b (
    .CLK(CLK), .RST(RST), .start_i(start_i), .abort_i(abort_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(b_ready), .col_o(b_col), .row_o(b_row),
    .addr_o(b_addr), .pix_acc_o(b_acc), .win_valid_o(b_win), .center_col_o(b_ccol),
    .center_row_o(b_crow), .busy_o(b_busy), .done_o(b_done)
  );

  logic sel = 1'b0;
  logic m_ready, m_acc, m_win, m_busy, m_done;
  logic [9:0] m_col, m_row, m_ccol, m_crow;
  logic [18:0] m_addr;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_acc   = sel ? b_acc   : a_acc;
  assign m_win   = sel ? b_win   : a_win;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_col   = sel ? b_col   : a_col;
  assign m_row   = sel ? b_row   : a_row;
  assign m_ccol  = sel ? b_ccol  : a_ccol;
  assign m_crow  = sel ? b_crow  : a_crow;
  assign m_addr  = sel ? b_addr  : a_addr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic rst, start, abort, valid;
    logic ready, busy, acc;
    int   col, row, addr;
    logic win, done;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  vec_t tbl [14];

  // One full frame from IDLE; checks every strobe against a pixel-index model.
  task automatic run_frame(input int w, input int h, input int bub);
    int k = 0, nwin = 0, last_c = -1, exp_lat, exp_win_n, kr, kc, idx;
    bit got_done = 0;
    bit exp_acc, bad;
    bit seen [64];
`ifdef MEDIAN_BORDER_REPLICATE_EN
    exp_lat = w + 2;
    exp_win_n = w * h;
`else
    exp_lat = 1;
    exp_win_n = (w - 2) * (h - 2);
`endif
    foreach (seen[i]) seen[i] = 1'b0;
    start_i = 1'b1; pix_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    chk("frame_start_ready", m_ready, 1);
    chk("frame_start_busy", m_busy, 1);
    for (int c = 0; c < 400 && !got_done; c++) begin
      pix_valid_i = ($urandom_range(99) >= bub);
      start_i = (c == 3);
      exp_acc = pix_valid_i && (k < w * h);
      kr = k / w;
      kc = k % w;
      tick();
      start_i = 1'b0;
      chk("acc", m_acc, exp_acc);
      if (m_acc) begin
        chk("col", m_col, kc);
        chk("row", m_row, kr);
        chk("addr", m_addr, k);
        chk("addr_rel", m_addr, m_row * w + m_col);
        if (k == w * h - 1) last_c = c;
        k++;
      end else if (k > 0) begin
        chk("hold_col", m_col, (k - 1) % w);
        chk("hold_addr", m_addr, k - 1);
      end
`ifdef MEDIAN_BORDER_REPLICATE_EN
      if (m_win) begin
        bad = (m_crow >= h) || (m_ccol >= w);
        if (!bad) begin
          idx = m_crow * w + m_ccol;
          bad = seen[idx];
          seen[idx] = 1'b1;
        end
        chk("win_centre_once", bad, 0);
        nwin++;
      end
`else
      chk("win", m_win, exp_acc && kr >= 2 && kc >= 2);
      if (m_win) begin
        chk("centre_col", m_ccol, kc - 1);
        chk("centre_row", m_crow, kr - 1);
        nwin++;
      end
`endif
      if (k == w * h) chk("ready_after_last", m_ready, 0);
      if (m_done) begin
        chk("done_latency", c - last_c, exp_lat);
        got_done = 1;
      end
    end
    pix_valid_i = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    chk("strobes", k, w * h);
    chk("windows", nwin, exp_win_n);
  endtask

  initial begin
    //            rst start abort valid | ready busy acc  col row addr win done
    tbl[0]  = '{H, L, L, L,  L, L, L,  0, 0, 0,  L, L};
    tbl[1]  = '{L, L, L, H,  L, L, L,  0, 0, 0,  L, L};
    tbl[2]  = '{L, H, H, L,  L, L, L,  0, 0, 0,  L, L};
    tbl[3]  = '{L, H, L, L,  H, H, L,  0, 0, 0,  L, L};
    tbl[4]  = '{L, H, L, H,  H, H, H,  0, 0, 0,  L, L};
    tbl[5]  = '{L, L, L, H,  H, H, H,  1, 0, 1,  L, L};
    tbl[6]  = '{L, L, L, L,  H, H, L,  1, 0, 1,  L, L};
    tbl[7]  = '{L, L, L, H,  H, H, H,  2, 0, 2,  L, L};
    tbl[8]  = '{L, L, L, H,  H, H, H,  3, 0, 3,  L, L};
    tbl[9]  = '{L, L, L, H,  H, H, H,  0, 1, 4,  L, L};
    tbl[10] = '{L, L, H, L,  L, L, L,  0, 1, 4,  L, L};
    tbl[11] = '{L, L, L, L,  L, L, L,  0, 1, 4,  L, L};
    tbl[12] = '{L, H, L, L,  H, H, L,  0, 1, 4,  L, L};
    tbl[13] = '{L, L, L, H,  H, H, H,  0, 0, 0,  L, L};

    sel = 1'b0;
    for (int i = 0; i < 14; i++) begin
      RST = tbl[i].rst; start_i = tbl[i].start;
      abort_i = tbl[i].abort; pix_valid_i = tbl[i].valid;
      tick();
      chk($sformatf("v%0d_ready", i), m_ready, tbl[i].ready);
      chk($sformatf("v%0d_busy", i), m_busy, tbl[i].busy);
      chk($sformatf("v%0d_acc", i), m_acc, tbl[i].acc);
      chk($sformatf("v%0d_col", i), m_col, tbl[i].col);
      chk($sformatf("v%0d_row", i), m_row, tbl[i].row);
      chk($sformatf("v%0d_addr", i), m_addr, tbl[i].addr);
      chk($sformatf("v%0d_win", i), m_win, tbl[i].win);
      chk($sformatf("v%0d_done", i), m_done, tbl[i].done);
    end
    RST = 1'b0; start_i = 1'b0; abort_i = 1'b0; pix_valid_i = 1'b0;

    RST = 1'b1; tick(); RST = 1'b0;
    run_frame(4, 3, 0);
    tick();
    chk("done_pulse_width", m_done, 0);
    run_frame(4, 3, 0);

    // abort after pixel 7 of a 4x3 frame
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    pix_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("abort_pre_col", m_col, 3);
    chk("abort_pre_row", m_row, 1);
    chk("abort_pre_addr", m_addr, 7);
    pix_valid_i = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_ready", m_ready, 0);
    chk("abort_busy", m_busy, 0);
    chk("abort_acc", m_acc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", m_done, 0);
      chk("abort_idle_ready", m_ready, 0);
    end

    RST = 1'b1; tick(); RST = 1'b0;
    sel = 1'b1;
    run_frame(5, 4, 40);

    // reset in the middle of a 5x4 frame, with start and valid also high
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    pix_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rst_pre_col", m_col, 2);
    chk("rst_pre_row", m_row, 1);
    RST = 1'b1; start_i = 1'b1;
    tick();
    chk("rst_ready", m_ready, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_acc", m_acc, 0);
    chk("rst_col", m_col, 0);
    chk("rst_row", m_row, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_win", m_win, 0);
    chk("rst_done", m_done, 0);
    chk("rst_ccol", m_ccol, 0);
    chk("rst_crow", m_crow, 0);
    RST = 1'b0; start_i = 1'b0; pix_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", m_done, 0);
      chk("rst_idle_ready", m_ready, 0);
    end
    start_i = 1'b1; tick(); start_i = 1'b0;
    pix_valid_i = 1'b1; tick(); pix_valid_i = 1'b0;
    chk("restart_acc", m_acc, 1);
    chk("restart_col", m_col, 0);
    chk("restart_row", m_row, 0);
    chk("restart_addr", m_addr, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
